// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, one bit per cycle, LSB first.
// Valid/ready handshake on both sides; results held while out_valid.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_nx;
    logic             d;
    logic             am;
    logic             bm;
    logic             last;

    assign d      = sa[0] ^ sb[0] ^ br;
    assign br_nx  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign res_nx = {d, res[WIDTH-1:1]};
    assign last   = (cnt == CW'(WIDTH - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = SHIFT;
            SHIFT:   if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            res  <= '0;
            cnt  <= '0;
            br   <= 1'b0;
            am   <= 1'b0;
            bm   <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                sa  <= a;
                sb  <= b;
                br  <= bin;
                cnt <= '0;
                res <= '0;
                am  <= a[WIDTH-1];
                bm  <= b[WIDTH-1];
            end
        end else if (state == SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= br_nx;
            cnt <= cnt + CW'(1);
            res <= res_nx;
            // Final bit: publish the assembled result and flags together
            if (last) begin
                diff <= res_nx;
                bout <= br_nx;
                ovf  <= (am != bm) & (d != am);
                zero <= (res_nx == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH = 4).
// Each scenario task does its own inline comparisons.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    int n_checks = 0;
    int n_fail = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .bin(bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff(diff),
        .bout(bout),
        .ovf(ovf),
        .zero(zero)
    );

    always #5 clk = ~clk;

    // Present operands, accept on the next edge, return edges until out_valid
    task automatic start_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic tbin, output int lat);
        @(negedge clk);
        a = ta;
        b = tb;
        bin = tbin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        n_checks++;
        if ({diff, bout, ovf, zero} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_out: diff=%0d bout=%b ovf=%b zero=%b, want 0", diff, bout, ovf, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        start_and_wait(4'd9, 4'd3, 1'b0, lat);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges, want 4", lat);
        end
        // 9 is -7 signed; -7 - 3 = -10 overflows the 4-bit range
        n_checks++;
        if ({diff, bout, ovf, zero} !== {4'd6, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL basic: diff=%0d bout=%b ovf=%b zero=%b, want 6 0 1 0", diff, bout, ovf, zero);
        end
        finish_op();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_borrow();
        int lat;
        start_and_wait(4'd3, 4'd5, 1'b0, lat);
        n_checks++;
        if (lat !== 4 || {diff, bout, ovf, zero} !== {4'd14, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL borrow: lat=%0d diff=%0d bout=%b ovf=%b zero=%b, want 4 14 1 0 0", lat, diff, bout, ovf, zero);
        end
        finish_op();
    endtask

    task automatic test_overflow();
        int lat;
        start_and_wait(4'd7, 4'd15, 1'b0, lat);
        n_checks++;
        if (lat !== 4 || {diff, bout, ovf, zero} !== {4'd8, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL overflow: lat=%0d diff=%0d bout=%b ovf=%b zero=%b, want 4 8 1 1 0", lat, diff, bout, ovf, zero);
        end
        finish_op();
    endtask

    task automatic test_zero();
        int lat;
        start_and_wait(4'd5, 4'd5, 1'b0, lat);
        n_checks++;
        if (lat !== 4 || {diff, bout, ovf, zero} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL zero: lat=%0d diff=%0d bout=%b ovf=%b zero=%b, want 4 0 0 0 1", lat, diff, bout, ovf, zero);
        end
        finish_op();
    endtask

    task automatic test_borrow_in();
        int lat;
        start_and_wait(4'd0, 4'd0, 1'b1, lat);
        n_checks++;
        if (lat !== 4 || {diff, bout, ovf, zero} !== {4'd15, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL borrow_in: lat=%0d diff=%0d bout=%b ovf=%b zero=%b, want 4 15 1 0 0", lat, diff, bout, ovf, zero);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        a = 4'd3;
        b = 4'd5;
        bin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        // New operands during SHIFT must be ignored
        a = 4'd1;
        b = 4'd1;
        bin = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ready: in_ready=%b during SHIFT, want 0", in_ready);
        end
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (lat !== 4 || diff !== 4'd14 || bout !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_busy: lat=%0d diff=%0d bout=%b, want 4 14 1", lat, diff, bout);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {diff, bout, ovf, zero} !== {4'd14, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_%0d: ov=%b ir=%b diff=%0d bout=%b ovf=%b zero=%b, want 1 0 14 1 0 0",
                         i, out_valid, in_ready, diff, bout, ovf, zero);
            end
        end
        finish_op();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        @(negedge clk);
        a = 4'd9;
        b = 4'd3;
        bin = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int e = 0; e < 14 && acc.size() < 2; e++) begin
            if (in_ready) acc.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc.size() < 2 || acc[1] - acc[0] !== W + 2) begin
            n_fail++;
            $display("FAIL back_to_back: %0d accepts seen, spacing %0d, want %0d",
                     acc.size(), acc.size() < 2 ? -1 : acc[1] - acc[0], W + 2);
        end
        // Drain the second operation
        for (int i = 0; i < 10 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        a = 4'd3;
        b = 4'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b diff=%0d, want 0 1 0", out_valid, in_ready, diff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_and_wait(4'd12, 4'd4, 1'b0, lat);
        n_checks++;
        if (lat !== 4 || {diff, bout, ovf, zero} !== {4'd8, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset: lat=%0d diff=%0d bout=%b ovf=%b zero=%b, want 4 8 0 0 0", lat, diff, bout, ovf, zero);
        end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_zero();
        test_borrow_in();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
